// File: rtl/rename_pkg.sv
// Shared rename-stage definitions: default register-file sizes, derived
// index widths, register typedefs and the free-list pointer sizing helper.
package rename_pkg;

    localparam int RN_ARCH_REGS = 32;
    localparam int RN_PHYS_REGS = 64;
    localparam int RN_AREG_W    = $clog2(RN_ARCH_REGS);
    localparam int RN_PREG_W    = $clog2(RN_PHYS_REGS);
    localparam int RN_FL_DEPTH  = RN_PHYS_REGS - RN_ARCH_REGS;

    typedef logic [RN_AREG_W-1:0] areg_t;
    typedef logic [RN_PREG_W-1:0] preg_t;

    // Free-list pointer width: index bits plus one wrap bit.
    function automatic int fl_ptr_width(input int depth);
        if (depth <= 1) begin
            return 2;
        end else begin
            return $clog2(depth) + 1;
        end
    endfunction

endpackage

// File: rtl/rename_free_list.sv
// Circular free list of physical registers. head is the speculative
// allocation pointer, chead the committed allocation pointer and tail the
// return pointer. A flush rewinds head to chead in a single cycle.
module rename_free_list
    import rename_pkg::*;
#(
    parameter int ARCH_REGS = RN_ARCH_REGS,
    parameter int PHYS_REGS = RN_PHYS_REGS
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pop,
    input  logic                          push,
    input  logic [$clog2(PHYS_REGS)-1:0]  push_data,
    input  logic                          commit,
    input  logic                          flush,
    output logic [$clog2(PHYS_REGS)-1:0]  pop_data,
    output logic [$clog2(PHYS_REGS):0]    count
);

    localparam int PREG_W   = $clog2(PHYS_REGS);
    localparam int CNT_W    = PREG_W + 1;
    localparam int FL_DEPTH = PHYS_REGS - ARCH_REGS;
    localparam int PTR_W    = fl_ptr_width(FL_DEPTH);
    localparam int IDX_W    = PTR_W - 1;

    logic [PREG_W-1:0] fl_mem_r [FL_DEPTH];
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  chead_r;
    logic [PTR_W-1:0]  tail_r;
    logic [CNT_W-1:0]  count_s;

    // Advance a pointer modulo FL_DEPTH, toggling the wrap bit on wrap.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p[IDX_W-1:0] == IDX_W'(FL_DEPTH - 1)) begin
            r = {~p[PTR_W-1], {IDX_W{1'b0}}};
        end else begin
            r = {p[PTR_W-1], p[IDX_W-1:0] + IDX_W'(1)};
        end
        return r;
    endfunction

    // Pointer and storage update: push/commit on retire, pop or rewind on flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < FL_DEPTH; k++) begin
                fl_mem_r[k] <= PREG_W'(ARCH_REGS + k);
            end
            head_r  <= {PTR_W{1'b0}};
            chead_r <= {PTR_W{1'b0}};
            tail_r  <= {1'b1, {IDX_W{1'b0}}};
        end else begin
            if (push) begin
                fl_mem_r[tail_r[IDX_W-1:0]] <= push_data;
                tail_r <= ptr_inc(tail_r);
            end
            if (commit) begin
                chead_r <= ptr_inc(chead_r);
            end
            if (flush) begin
                head_r <= commit ? ptr_inc(chead_r) : chead_r;
            end else if (pop) begin
                head_r <= ptr_inc(head_r);
            end
        end
    end

    // Occupancy from tail minus head, accounting for the wrap bit.
    always_comb begin
        if (tail_r[PTR_W-1] == head_r[PTR_W-1]) begin
            count_s = CNT_W'(tail_r[IDX_W-1:0]) - CNT_W'(head_r[IDX_W-1:0]);
        end else begin
            count_s = CNT_W'(FL_DEPTH) + CNT_W'(tail_r[IDX_W-1:0])
                    - CNT_W'(head_r[IDX_W-1:0]);
        end
    end

    assign pop_data = fl_mem_r[head_r[IDX_W-1:0]];
    assign count    = count_s;

endmodule

// File: rtl/rename_map_unit.sv
// Register rename stage: speculative and committed RATs, a checkpointed free
// list, and a single registered output slot with valid/ready handshake.
module rename_map_unit
    import rename_pkg::*;
#(
    parameter int ARCH_REGS = RN_ARCH_REGS,
    parameter int PHYS_REGS = RN_PHYS_REGS,
    localparam int AREG_W   = $clog2(ARCH_REGS),
    localparam int PREG_W   = $clog2(PHYS_REGS)
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AREG_W-1:0] in_rs1,
    input  logic [AREG_W-1:0] in_rs2,
    input  logic [AREG_W-1:0] in_rd,
    input  logic              in_writes_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PREG_W-1:0] out_ps1,
    output logic [PREG_W-1:0] out_ps2,
    output logic [PREG_W-1:0] out_pd,
    output logic [PREG_W-1:0] out_old_pd,
    input  logic              retire_valid,
    input  logic              retire_writes_rd,
    input  logic [AREG_W-1:0] retire_rd,
    input  logic [PREG_W-1:0] retire_pd,
    input  logic [PREG_W-1:0] retire_old_pd,
    input  logic              flush,
    output logic [PREG_W:0]   free_count
);

    logic [PREG_W-1:0] rat_r  [ARCH_REGS];
    logic [PREG_W-1:0] crat_r [ARCH_REGS];

    logic              out_valid_r;
    logic [PREG_W-1:0] out_ps1_r;
    logic [PREG_W-1:0] out_ps2_r;
    logic [PREG_W-1:0] out_pd_r;
    logic [PREG_W-1:0] out_old_pd_r;

    logic              alloc_s;
    logic              in_ready_s;
    logic              accept_s;
    logic              pop_s;
    logic              retire_s;
    logic [PREG_W-1:0] fl_head_s;
    logic [PREG_W:0]   fl_count_s;
    logic [PREG_W-1:0] ps1_s;
    logic [PREG_W-1:0] ps2_s;
    logic [PREG_W-1:0] old_pd_s;

    assign alloc_s  = in_writes_rd && (in_rd != {AREG_W{1'b0}});
    assign retire_s = retire_valid && retire_writes_rd && (retire_rd != {AREG_W{1'b0}});
    assign accept_s = in_valid && in_ready_s;
    assign pop_s    = accept_s && alloc_s;

    // Acceptance: no flush, output slot free or draining, and a free register if one is needed.
    always_comb begin
        in_ready_s = 1'b0;
        if (flush) begin
            in_ready_s = 1'b0;
        end else if (out_valid_r && !out_ready) begin
            in_ready_s = 1'b0;
        end else if (alloc_s && (fl_count_s == {(PREG_W+1){1'b0}})) begin
            in_ready_s = 1'b0;
        end else begin
            in_ready_s = 1'b1;
        end
    end

    // Source and previous-destination lookups; x0 always reads physical 0.
    always_comb begin
        ps1_s    = {PREG_W{1'b0}};
        ps2_s    = {PREG_W{1'b0}};
        old_pd_s = {PREG_W{1'b0}};
        if (in_rs1 != {AREG_W{1'b0}}) begin
            ps1_s = rat_r[in_rs1];
        end else begin
            ps1_s = {PREG_W{1'b0}};
        end
        if (in_rs2 != {AREG_W{1'b0}}) begin
            ps2_s = rat_r[in_rs2];
        end else begin
            ps2_s = {PREG_W{1'b0}};
        end
        if (alloc_s) begin
            old_pd_s = rat_r[in_rd];
        end else begin
            old_pd_s = {PREG_W{1'b0}};
        end
    end

    rename_free_list #(
        .ARCH_REGS (ARCH_REGS),
        .PHYS_REGS (PHYS_REGS)
    ) u_free_list (
        .clk       (clk),
        .rst       (rst),
        .pop       (pop_s),
        .push      (retire_s),
        .push_data (retire_old_pd),
        .commit    (retire_s),
        .flush     (flush),
        .pop_data  (fl_head_s),
        .count     (fl_count_s)
    );

    // RAT maintenance: committed map on retire, speculative map on allocate or flush restore.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                rat_r[i]  <= PREG_W'(i);
                crat_r[i] <= PREG_W'(i);
            end
        end else begin
            if (retire_s) begin
                crat_r[retire_rd] <= retire_pd;
            end
            if (flush) begin
                for (int i = 0; i < ARCH_REGS; i++) begin
                    rat_r[i] <= (retire_s && (retire_rd == AREG_W'(i))) ? retire_pd : crat_r[i];
                end
            end else if (pop_s) begin
                rat_r[in_rd] <= fl_head_s;
            end
        end
    end

    // Output slot: load on accept, clear on flush or drain, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r  <= 1'b0;
            out_ps1_r    <= {PREG_W{1'b0}};
            out_ps2_r    <= {PREG_W{1'b0}};
            out_pd_r     <= {PREG_W{1'b0}};
            out_old_pd_r <= {PREG_W{1'b0}};
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            out_valid_r  <= 1'b1;
            out_ps1_r    <= ps1_s;
            out_ps2_r    <= ps2_s;
            out_pd_r     <= alloc_s ? fl_head_s : {PREG_W{1'b0}};
            out_old_pd_r <= old_pd_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_r;
    assign out_ps1    = out_ps1_r;
    assign out_ps2    = out_ps2_r;
    assign out_pd     = out_pd_r;
    assign out_old_pd = out_old_pd_r;
    assign free_count = fl_count_s;

endmodule

// File: tb/tb_rename_map_unit.sv
// Scoreboard bench for rename_map_unit: directed vectors with hand-computed
// results, then a randomised phase against a queue-based reference model.
module tb_rename_map_unit;
    import rename_pkg::*;

    localparam int AW = 5;
    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, in_writes_rd;
    logic [AW-1:0] in_rs1, in_rs2, in_rd;
    logic          out_valid, out_ready;
    logic [PW-1:0] out_ps1, out_ps2, out_pd, out_old_pd;
    logic          retire_valid, retire_writes_rd;
    logic [AW-1:0] retire_rd;
    logic [PW-1:0] retire_pd, retire_old_pd;
    logic          flush;
    logic [PW:0]   free_count;

    typedef struct { int ps1; int ps2; int pd; int old; } exp_t;
    typedef struct { bit wr; int rd; int pd; int old; } rob_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // reference model state for the random phase
    int   m_rat[32];
    int   m_crat[32];
    int   m_fl[$];
    int   m_spec;
    bit   m_outv;
    rob_t m_rob[$];

    always #5 clk = ~clk;

    rename_map_unit dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_writes_rd(in_writes_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ps1(out_ps1), .out_ps2(out_ps2), .out_pd(out_pd), .out_old_pd(out_old_pd),
        .retire_valid(retire_valid), .retire_writes_rd(retire_writes_rd),
        .retire_rd(retire_rd), .retire_pd(retire_pd), .retire_old_pd(retire_old_pd),
        .flush(flush), .free_count(free_count)
    );

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Scoreboard monitor: compare each consumed output against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_output: actual pd=%0d required=no output", out_pd);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_ps1", out_ps1, e.ps1);
                check("out_ps2", out_ps2, e.ps2);
                check("out_pd", out_pd, e.pd);
                check("out_old_pd", out_old_pd, e.old);
            end
        end
    end

    // A retire that pushes into a full free list is illegal stimulus.
    always @(negedge clk) begin
        if (!rst && retire_valid && retire_writes_rd && retire_rd != 0 && free_count == 7'd32) begin
            n_checks++;
            n_errors++;
            $display("FAIL illegal_push: actual free_count=%0d required below 32", free_count);
        end
    end

    task automatic reset_dut();
        rst = 1'b1;
        in_valid = 1'b0; in_writes_rd = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        out_ready = 1'b1;
        retire_valid = 1'b0; retire_writes_rd = 1'b0; retire_rd = '0;
        retire_pd = '0; retire_old_pd = '0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic do_rename(input int rs1, input int rs2, input int rd, input bit wr,
                             input int e1, input int e2, input int epd, input int eold);
        bit got;
        got = 1'b0;
        in_valid = 1'b1; in_rs1 = AW'(rs1); in_rs2 = AW'(rs2); in_rd = AW'(rd); in_writes_rd = wr;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
        end
        if (!got) begin
            in_valid = 1'b0;
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: actual in_ready=0 required=1 (rd=%0d)", rd);
        end else begin
            exp_q.push_back('{e1, e2, epd, eold});
        end
        @(posedge clk);
        #1 in_valid = 1'b0; in_writes_rd = 1'b0;
    endtask

    initial begin
        reset_dut();

        // reset state and first lookup
        @(negedge clk);
        check("rst_free_count", free_count, 32);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_pd", out_pd, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        do_rename(5, 0, 0, 0, 5, 0, 0, 0);

        // allocation and dependent read
        do_rename(1, 2, 3, 1, 1, 2, 32, 3);
        do_rename(3, 0, 3, 1, 32, 0, 33, 32);
        do_rename(3, 3, 0, 0, 33, 33, 0, 0);
        @(negedge clk);
        check("alloc_free_count", free_count, 30);

        // x0 destination allocates nothing
        @(posedge clk); #1;
        do_rename(0, 0, 0, 1, 0, 0, 0, 0);
        @(negedge clk);
        check("x0_free_count", free_count, 30);
        @(posedge clk); #1;

        // exhaust the free list
        for (int k = 0; k < 30; k++) begin
            do_rename(0, 0, 5, 1, 0, 0, 34 + k, (k == 0) ? 5 : 33 + k);
        end
        @(negedge clk);
        check("empty_free_count", free_count, 0);
        @(posedge clk); #1;
        do_rename(5, 3, 0, 0, 63, 33, 0, 0);

        // blocked allocation released by a retire one cycle later
        in_valid = 1'b1; in_rs1 = '0; in_rs2 = '0; in_rd = 5'd6; in_writes_rd = 1'b1;
        @(negedge clk);
        check("ready_empty", in_ready, 0);
        @(posedge clk); #1;
        retire_valid = 1'b1; retire_writes_rd = 1'b1; retire_rd = 5'd3;
        retire_pd = 6'd32; retire_old_pd = 6'd7;
        @(negedge clk);
        check("ready_no_bypass", in_ready, 0);
        @(posedge clk); #1;
        retire_valid = 1'b0; retire_writes_rd = 1'b0;
        @(negedge clk);
        check("ready_after_retire", in_ready, 1);
        if (in_ready) exp_q.push_back('{0, 0, 7, 6});
        @(posedge clk); #1;
        in_valid = 1'b0; in_writes_rd = 1'b0;
        @(negedge clk);
        check("realloc_free_count", free_count, 0);
        @(posedge clk); #1;

        // back-pressure holds the output slot
        out_ready = 1'b0;
        do_rename(6, 5, 0, 0, 7, 63, 0, 0);
        in_valid = 1'b1; in_rs1 = 5'd1; in_rs2 = '0; in_rd = '0; in_writes_rd = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_ps1", out_ps1, 7);
            check("hold_ps2", out_ps2, 63);
            check("hold_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        do_rename(1, 0, 0, 0, 1, 0, 0, 0);

        // flush with a simultaneous retire
        reset_dut();
        do_rename(0, 0, 1, 1, 0, 0, 32, 1);
        do_rename(0, 0, 2, 1, 0, 0, 33, 2);
        do_rename(0, 0, 4, 1, 0, 0, 34, 4);
        in_valid = 1'b1; in_rd = 5'd9; in_writes_rd = 1'b1;
        retire_valid = 1'b1; retire_writes_rd = 1'b1; retire_rd = 5'd1;
        retire_pd = 6'd32; retire_old_pd = 6'd1;
        flush = 1'b1;
        @(negedge clk);
        check("ready_flush", in_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0; retire_valid = 1'b0; retire_writes_rd = 1'b0;
        in_valid = 1'b0; in_writes_rd = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("flush_out_valid", out_valid, 0);
        check("flush_free_count", free_count, 32);
        @(posedge clk); #1;
        do_rename(1, 2, 9, 1, 32, 2, 33, 9);
        do_rename(4, 0, 0, 0, 4, 0, 0, 0);

        // randomised regression against the reference model
        reset_dut();
        for (int i = 0; i < 32; i++) begin
            m_rat[i] = i;
            m_crat[i] = i;
        end
        m_fl.delete();
        for (int k = 0; k < 32; k++) m_fl.push_back(32 + k);
        m_spec = 0;
        m_outv = 1'b0;
        m_rob.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            bit   do_ret, alloc, m_ready, acc;
            rob_t r;
            exp_t e;
            int   m_fc;
            out_ready    = ($urandom_range(0, 3) != 0);
            in_valid     = ($urandom_range(0, 2) != 0);
            in_rs1       = AW'($urandom_range(0, 31));
            in_rs2       = AW'($urandom_range(0, 31));
            in_rd        = AW'($urandom_range(0, 31));
            in_writes_rd = ($urandom_range(0, 3) != 0);
            do_ret       = (m_rob.size() > 0) && ($urandom_range(0, 1) == 1);
            if (do_ret) begin
                r = m_rob.pop_front();
                retire_valid = 1'b1; retire_writes_rd = r.wr; retire_rd = AW'(r.rd);
                retire_pd = PW'(r.pd); retire_old_pd = PW'(r.old);
            end else begin
                retire_valid = 1'b0; retire_writes_rd = 1'b0;
            end
            flush = ($urandom_range(0, 29) == 0);
            @(negedge clk);
            alloc   = in_writes_rd && (in_rd != 0);
            m_fc    = m_fl.size() - m_spec;
            m_ready = !flush && (!m_outv || out_ready) && (!alloc || m_fc != 0);
            check("rnd_in_ready", in_ready, m_ready);
            check("rnd_free_count", free_count, m_fc);
            acc = in_valid && m_ready;
            e.ps1 = (in_rs1 == 0) ? 0 : m_rat[in_rs1];
            e.ps2 = (in_rs2 == 0) ? 0 : m_rat[in_rs2];
            e.pd  = alloc ? m_fl[m_spec] : 0;
            e.old = alloc ? m_rat[in_rd] : 0;
            if (acc) exp_q.push_back(e);
            if (do_ret && r.wr && r.rd != 0) begin
                m_crat[r.rd] = r.pd;
                void'(m_fl.pop_front());
                m_spec--;
                m_fl.push_back(r.old);
            end
            if (flush) begin
                m_rat = m_crat;
                m_spec = 0;
                m_rob.delete();
                m_outv = 1'b0;
            end else if (acc) begin
                if (alloc) begin
                    m_rat[in_rd] = e.pd;
                    m_spec++;
                end
                m_rob.push_back('{in_writes_rd, int'(in_rd), e.pd, e.old});
                m_outv = 1'b1;
            end else if (out_ready) begin
                m_outv = 1'b0;
            end
            @(posedge clk); #1;
            if (flush) exp_q.delete();
        end
        in_valid = 1'b0; retire_valid = 1'b0; retire_writes_rd = 1'b0;
        flush = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rename_map_unit.md
# rename_map_unit

Parametrised register-rename stage sitting between decode and dispatch. It maps architectural source and destination registers to physical registers through a speculative RAT and a circular free list, with a valid/ready handshake on both sides. It maintains a committed RAT updated at retire, and returns each retired instruction's previous physical register to the free list. On a pipeline flush it restores the speculative state in one cycle.

## Interface
- ARCH_REGS, 32, architectural register count; register 0 is hardwired zero.
- PHYS_REGS, 64, physical register count; must be greater than ARCH_REGS.
- AREG_W, $clog2(ARCH_REGS), architectural index width (derived).
- PREG_W, $clog2(PHYS_REGS), physical index width (derived).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  decoded instruction is present.
- in_ready  out  1  rename accepts this cycle.
- in_rs1, in_rs2, in_rd  in  AREG_W  architectural sources and destination.
- in_writes_rd  in  1  instruction writes rd. Low for stores, branches and NOPs.
- out_valid  out  1  renamed instruction held in the output register.
- out_ready  in  1  dispatch consumes the output.
- out_ps1, out_ps2, out_pd, out_old_pd  out  PREG_W  renamed sources, new destination, and previous mapping of rd.
- retire_valid  in  1  ROB retires one instruction.
- retire_writes_rd  in  1  the retiring instruction allocated a register.
- retire_rd  in  AREG_W  retiring architectural destination.
- retire_pd, retire_old_pd  in  PREG_W  retiring new and old physical registers.
- flush  in  1  discard all unretired renames.
- free_count  out  PREG_W+1  number of entries in the free list.

## Operation
- **State**
  - Speculative RAT[ARCH_REGS] and committed CRAT[ARCH_REGS], each holding PREG_W-bit entries.
  - Free list FL with FL_DEPTH = PHYS_REGS − ARCH_REGS entries.
  - Pointers `head` (allocation), `chead` (committed allocation) and `tail` (return). Each is one bit wider than log2(FL_DEPTH) so wrap is explicit.
  - Pointers wrap modulo FL_DEPTH, with the extra bit toggling on wrap.
  - free_count = tail − head.
- **Allocation needed:** `alloc` = in_writes_rd && in_rd != 0.
- **in_ready** = !flush && (!out_valid || out_ready) && (!alloc || free_count != 0).
- **Accept** (in_valid && in_ready):
  - out_ps1 = RAT[in_rs1] and out_ps2 = RAT[in_rs2]; register 0 always maps to 0.
  - If alloc: out_pd = FL[head], out_old_pd = RAT[in_rd], RAT[in_rd] = FL[head], and head advances.
  - Otherwise out_pd = 0, out_old_pd = 0, and nothing changes.
  - out_valid is set.
- **Output drain:** out_valid clears on out_ready when no new accept occurs in the same cycle.
- **Retire** (retire_valid && retire_writes_rd && retire_rd != 0):
  - CRAT[retire_rd] = retire_pd.
  - FL[tail] = retire_old_pd; tail advances.
  - chead advances.
- **Retire without a destination:** no state change.
- **Flush:**
  - RAT = CRAT, where CRAT includes any same-cycle retire update.
  - head = chead, including any same-cycle chead advance.
  - out_valid = 0. Any same-cycle accept is suppressed, since in_ready is low.
- **Illegal input:** a retire that pushes while free_count == FL_DEPTH is illegal; the bench asserts on it.

## Timing
- **Reset values:**
  - RAT[i] = CRAT[i] = i.
  - FL[k] = ARCH_REGS + k.
  - head = chead = 0; tail = FL_DEPTH with the wrap bit set, so free_count = FL_DEPTH.
  - out_valid = 0; out_ps1, out_ps2, out_pd and out_old_pd all 0.
- **Reset mid-operation** discards everything, including flush and retire inputs in that cycle.
- **Latency:** one cycle from accept to out_valid. Outputs are registered and stay stable while out_valid && !out_ready.
- **Back-to-back dependents:** a RAT write at edge N is visible to the accept at edge N+1, so there is no bypass hazard.
- **Retire and allocate in the same cycle:** in_ready uses the registered free_count. An entry pushed in cycle N is allocatable from cycle N+1; there is no same-cycle bypass.
- **Free list empty:** in_ready is low only for alloc instructions. Non-writing instructions still pass.
- **Priority within a cycle:** rst > flush > accept. Retire is always applied unless rst is asserted.

## Structure
- **Shared package `rename_pkg`:** ARCH_REGS and PHYS_REGS defaults, derived widths, and the preg_t/areg_t typedefs. The ROB imports the same package.
- **Sub-module `rename_free_list`:** a circular FIFO with a third checkpoint pointer (chead) and flush restore. It exposes pop, push, commit, flush and count.
- **Top level:** holds both RATs and the handshake/output register.

## Test plan
- **Reset:** rst for 2 cycles -> free_count = 32, out_valid = 0, renaming rs1 = 5 gives out_ps1 = 5.
- **Allocation and dependent read:** rename rd = 3 twice, then rs1 = 3 -> out_pd = 32, then 33 with out_old_pd = 32, then out_ps1 = 33; free_count = 30.
- **x0 and non-writing instructions:** rd = 0 with in_writes_rd = 1 -> out_pd = 0, free_count unchanged. A store (in_writes_rd = 0) is accepted while free_count = 0.
- **Exhaustion and back-pressure:**
  - 32 allocations -> in_ready low for the next alloc.
  - In that state, a retire with retire_old_pd = 7 -> in_ready high the next cycle, and the allocated pd = 7.
  - Hold out_ready = 0 -> outputs stable, no RAT change.
- **Flush with simultaneous retire:**
  - Rename rd = 1 (p32), rd = 2 (p33), rd = 4 (p34).
  - In one cycle, retire rd = 1/p32/old 1 and assert flush.
  - Required: RAT[1] = 32, RAT[2] = 2, RAT[4] = 4, free_count = 32. The next alloc gets p33, and out_valid is cleared.
- **Random regression:** randomised valid/ready/retire/flush against a reference model -> no duplicate live pregs, and the committed and free registers together always cover all 64.
